fetch_unit: RTL and testbench

//  Parametrised instruction-fetch stage for the pipelined MIPS core. Owns the PC, issues

---
 rtl/fetch_pkg.sv | 25 ++
 rtl/fetch_fifo.sv | 61 ++++++
 rtl/fetch_unit.sv | 114 +++++++++++
 tb/tb_fetch_unit.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// The fetch_entry_t pc field is PC_MAX_W wide; fetch_unit supports ADDR_W up to PC_MAX_W.
package fetch_pkg;

  localparam int unsigned INST_W   = 32;
  localparam int unsigned PC_MAX_W = 32;
  localparam int unsigned PC_INC   = 4;
  localparam int unsigned PERF_W   = 32;

  localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0000;

  typedef struct packed {
    logic [PC_MAX_W-1:0] pc;
    logic [INST_W-1:0]   inst;
  } fetch_entry_t;

  // Saturating add for the optional event counters
  function automatic logic [PERF_W-1:0] sat_add(input logic [PERF_W-1:0] a,
                                                input logic [PERF_W-1:0] b);
    logic [PERF_W:0] sum;
    sum = (PERF_W+1)'(a) + (PERF_W+1)'(b);
    return sum[PERF_W] ? {PERF_W{1'b1}} : sum[PERF_W-1:0];
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry first-word-fall-through FIFO of fetch entries.
// Flush dominates push and pop; head_o is only meaningful while empty_o is low.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  fetch_entry_t     entry_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output fetch_entry_t     head_o,
  output logic [CNT_W-1:0] count_o,
  output logic             empty_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             push_eff;
  logic             pop_eff;

  always_comb begin
    full     = (count == CNT_W'(DEPTH));
    empty_o  = (count == '0);
    pop_eff  = pop_i & ~empty_o & ~flush_i;
    push_eff = push_i & ~flush_i & (~full | pop_eff);
    head_o   = mem[rd_ptr];
    count_o  = count;
  end

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_eff) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_eff)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_eff, pop_eff})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are never read while the FIFO is empty
  always_ff @(posedge clk_i) begin
    if (push_eff && !rst_i) mem[wr_ptr] <= entry_i;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, 1-cycle imem requests, prefetch queue, IF/ID handshake, redirect.
// Optional event counters are built when FETCH_PERF_EN is defined.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  output logic                imem_req_o,
  output logic [ADDR_W-1:0]   imem_addr_o,
  input  logic [INST_W-1:0]   imem_rdata_i,
  input  logic                redirect_i,
  input  logic [ADDR_W-1:0]   redirect_pc_i,
  output logic                id_valid_o,
  input  logic                id_ready_i,
  output logic [ADDR_W-1:0]   id_pc_o,
  output logic [ADDR_W-1:0]   id_pc4_o,
  output logic [INST_W-1:0]   id_inst_o
`ifdef FETCH_PERF_EN
  ,
  output logic [PERF_W-1:0]   perf_fetch_o,
  output logic [PERF_W-1:0]   perf_flush_o,
  output logic [PERF_W-1:0]   perf_stall_o
`endif
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned CRD_W = CNT_W + 1;

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] inflight_pc_q;
  logic              inflight_q;

  logic              issue;
  logic              push;
  logic              pop;
  logic [CRD_W-1:0]  credit_used;
  fetch_entry_t      push_entry;
  fetch_entry_t      head;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty;

  // Credit counts the in-flight word but not this cycle's pop, so a push can never overflow
  always_comb begin
    credit_used = CRD_W'(fifo_count) + CRD_W'(inflight_q);
    issue       = ~rst_i & start_i & ~redirect_i & (credit_used < CRD_W'(DEPTH));
    push        = inflight_q & ~redirect_i & ~rst_i;
    pop         = id_valid_o & id_ready_i & ~redirect_i;
    push_entry  = '{pc: PC_MAX_W'(inflight_pc_q), inst: imem_rdata_i};
  end

  // PC and in-flight tracking; redirect clears the in-flight flag so its word is dropped
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else if (redirect_i) begin
      pc_q       <= redirect_pc_i & ~ADDR_W'(3);
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= issue;
      if (issue) begin
        inflight_pc_q <= pc_q;
        pc_q          <= pc_q + ADDR_W'(PC_INC);
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .entry_i (push_entry),
    .pop_i   (pop),
    .flush_i (redirect_i),
    .head_o  (head),
    .count_o (fifo_count),
    .empty_o (fifo_empty)
  );

  // An empty queue presents a NOP at pc 0 so ID sees a benign bubble
  always_comb begin
    imem_req_o  = issue;
    imem_addr_o = pc_q;
    id_valid_o  = ~fifo_empty;
    id_pc_o     = fifo_empty ? '0 : ADDR_W'(head.pc);
    id_pc4_o    = id_pc_o + ADDR_W'(PC_INC);
    id_inst_o   = fifo_empty ? NOP_INST : head.inst;
  end

`ifdef FETCH_PERF_EN
  // Flush count covers queued entries plus the word killed in flight
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_fetch_o <= '0;
      perf_flush_o <= '0;
      perf_stall_o <= '0;
    end else begin
      if (push) perf_fetch_o <= sat_add(perf_fetch_o, PERF_W'(1));
      if (redirect_i)
        perf_flush_o <= sat_add(perf_flush_o, PERF_W'(fifo_count) + PERF_W'(inflight_q));
      if (id_valid_o && !id_ready_i) perf_stall_o <= sat_add(perf_stall_o, PERF_W'(1));
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected pcs are queued by the stimulus and
// checked by an independent monitor on every IF/ID handshake.
module tb_fetch_unit;

  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned DEPTH    = 2;
  localparam logic [31:0] INST_KEY = 32'hC0DE_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'hDEAD_BEEF;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_pc4;
  logic [31:0] id_inst;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch;
  logic [31:0] perf_flush;
  logic [31:0] perf_stall;
`endif

  int          n_checks = 0;
  int          n_fail   = 0;
  int          issued_cnt = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  fetch_unit #(
    .ADDR_W   (ADDR_W),
    .DEPTH    (DEPTH),
    .RESET_PC (32'h0)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .start_i       (start),
    .imem_req_o    (imem_req),
    .imem_addr_o   (imem_addr),
    .imem_rdata_i  (imem_rdata),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .id_valid_o    (id_valid),
    .id_ready_i    (id_ready),
    .id_pc_o       (id_pc),
    .id_pc4_o      (id_pc4),
    .id_inst_o     (id_inst)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetch_o  (perf_fetch),
    .perf_flush_o  (perf_flush),
    .perf_stall_o  (perf_stall)
`endif
  );

  // Instruction memory: word = addr ^ key one cycle after a request, junk otherwise
  always @(posedge clk) begin
    imem_rdata <= imem_req ? (imem_addr ^ INST_KEY) : 32'hDEAD_BEEF;
    if (imem_req) issued_cnt <= issued_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every accepted head must match the next expected pc
  always @(negedge clk) begin : monitor
    logic [31:0] e;
    if (!rst && !redirect && id_valid && id_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_delivery: got pc %h, expected none", id_pc);
      end else begin
        e = exp_q.pop_front();
        check("id_pc", id_pc, e);
        check("id_pc4", id_pc4, e + 32'd4);
        check("id_inst", id_inst, e ^ INST_KEY);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_pcs(input logic [31:0] first, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(first + 32'(4 * i));
  endtask

  task automatic issue_n(input int n, input int base);
    for (int i = 0; i < 200; i++) begin
      if (issued_cnt - base >= n) break;
      cyc();
    end
    check("issue_count", 32'(issued_cnt - base), 32'(n));
    start = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100; i++) begin
      if (exp_q.size() == 0) break;
      cyc();
    end
    check("drain_left", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    check("drain_valid", 32'(id_valid), 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int base;
    rst = 1'b1; start = 1'b0; id_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
    cyc(); cyc();
    @(negedge clk);
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_valid", 32'(id_valid), 32'd0);
    check("rst_pc", id_pc, 32'd0);
    check("rst_pc4", id_pc4, 32'd4);
    check("rst_inst", id_inst, 32'd0);

    // Sequential fetch from RESET_PC
    cyc(); rst = 1'b0; start = 1'b1; id_ready = 1'b1;
    base = issued_cnt;
    expect_pcs(32'h0, 8);
    @(negedge clk);
    check("t1_req0", 32'(imem_req), 32'd1);
    check("t1_addr0", imem_addr, 32'h0);
    check("t1_valid0", 32'(id_valid), 32'd0);
    cyc(); @(negedge clk);
    check("t1_addr1", imem_addr, 32'h4);
    check("t1_valid1", 32'(id_valid), 32'd0);
    cyc(); @(negedge clk);
    check("t1_valid2", 32'(id_valid), 32'd1);
    check("t1_credit_stall", 32'(imem_req), 32'd0);
    issue_n(8, base);
    drain();

    // ID stall with DEPTH=2: requests stop once two words are owed
    cyc(); id_ready = 1'b0; start = 1'b1; redirect = 1'b1; redirect_pc = 32'h100;
    @(negedge clk);
    check("t2_redir_noreq", 32'(imem_req), 32'd0);
    cyc(); redirect = 1'b0;
    base = issued_cnt;
    expect_pcs(32'h100, 6);
    @(negedge clk);
    check("t2_addr0", imem_addr, 32'h100);
    check("t2_req0", 32'(imem_req), 32'd1);
    cyc(); @(negedge clk);
    check("t2_addr1", imem_addr, 32'h104);
    cyc(); @(negedge clk);
    check("t2_req_full", 32'(imem_req), 32'd0);
    cyc(); @(negedge clk);
    check("t2_req_held", 32'(imem_req), 32'd0);
    check("t2_head_pc", id_pc, 32'h100);
    cyc(); cyc(); @(negedge clk);
    check("t2_req_held2", 32'(imem_req), 32'd0);
    check("t2_head_valid", 32'(id_valid), 32'd1);
    cyc(); id_ready = 1'b1;
    issue_n(6, base);
    drain();

    // Redirect with one queued word and one in flight, ready high on a valid head
    cyc(); start = 1'b1; id_ready = 1'b0;
    @(negedge clk);
    check("t3_addr0", imem_addr, 32'h118);
    cyc(); @(negedge clk);
    check("t3_addr1", imem_addr, 32'h11C);
    cyc(); redirect = 1'b1; redirect_pc = 32'h43; id_ready = 1'b1;
    @(negedge clk);
    check("t3_head_before", id_pc, 32'h118);
    check("t3_redir_noreq", 32'(imem_req), 32'd0);
    cyc(); redirect = 1'b0;
    base = issued_cnt;
    expect_pcs(32'h40, 4);
    @(negedge clk);
    check("t3_flushed_valid", 32'(id_valid), 32'd0);
    check("t3_target_addr", imem_addr, 32'h40);
`ifdef FETCH_PERF_EN
    check("t4_perf_flush", perf_flush, 32'd2);
`endif
    cyc(); @(negedge clk);
    check("t3_valid_r2", 32'(id_valid), 32'd0);
    check("t3_addr_r2", imem_addr, 32'h44);
    cyc(); @(negedge clk);
    check("t3_target_visible", id_pc, 32'h40);
    issue_n(4, base);
    drain();

    // PC wrap at the top of the address space
    cyc(); start = 1'b0; redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    cyc(); redirect = 1'b0; start = 1'b1;
    base = issued_cnt;
    exp_q.push_back(32'hFFFF_FFFC);
    expect_pcs(32'h0, 2);
    @(negedge clk);
    check("t5_addr_top", imem_addr, 32'hFFFF_FFFC);
    cyc(); @(negedge clk);
    check("t5_addr_wrap", imem_addr, 32'h0);
    issue_n(3, base);
    drain();

    // Reset with a word in flight and a simultaneous redirect
    cyc(); start = 1'b1; id_ready = 1'b0;
    @(negedge clk);
    check("t6_addr_pre", imem_addr, 32'h8);
    cyc(); rst = 1'b1; redirect = 1'b1; redirect_pc = 32'h80; id_ready = 1'b1;
    @(negedge clk);
    check("t6_rst_req", 32'(imem_req), 32'd0);
    cyc(); rst = 1'b0; redirect = 1'b0;
    base = issued_cnt;
    expect_pcs(32'h0, 3);
    @(negedge clk);
    check("t6_valid", 32'(id_valid), 32'd0);
    check("t6_pc", id_pc, 32'h0);
    check("t6_pc4", id_pc4, 32'h4);
    check("t6_inst", id_inst, 32'h0);
    check("t6_resume_addr", imem_addr, 32'h0);
    cyc(); @(negedge clk);
    check("t6_valid_r2", 32'(id_valid), 32'd0);
    cyc(); @(negedge clk);
    check("t6_first_pc", id_pc, 32'h0);
    issue_n(3, base);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
